train_sequencer: RTL and testbench
==================================

// Module: train_sequencer
// PURPOSE
//  Epoch/phase controller placed in front of the multilayer perceptron top. Splits a combined sample+teacher stream
//  into the network input and teacher channels, and drives the network mode and learning rate.
//  Runs E epochs, each a TRAIN phase of NT samples then an INFER phase of NV samples. Changes mode only when the
//  pipeline is drained. Decays LR per epoch. Buffers teachers in an internal FIFO until the output layer takes them.
// PARAMETERS
//  NI=4        input neurons
//  NO=7        output neurons
//  NH1=6       neurons in last hidden layer (sets output/teacher element width)
//  WV=8        value width; WD=$clog2(NH1)+1+WV is the output/teacher element width (localparam)
//  MAXF=8      max samples in flight inside network; also teacher FIFO depth (power of 2, >=2)
//  WC=16       sample/epoch counter width
//  LR_DECAY=3  per-epoch LR decay shift: lr <= lr-(lr>>LR_DECAY), floor 1
// PORTS
//  iCLK               in  1          clock
//  iRST               in  1          reset, asynchronous, active-high
//  iStart             in  1          start pulse; ignored unless IDLE
//  iAbort             in  1          stop issuing, drain, return IDLE
//  iEpochs            in  WC         epoch count E (sampled on start)
//  iTrainSamples      in  WC         NT per epoch (sampled on start)
//  iInferSamples      in  WC         NV per epoch (sampled on start)
//  iLR                in  WV         initial learning rate (sampled on start)
//  iValid_AM_Sample   in  1          sample+teacher valid
//  oReady_AM_Sample   out 1          sample+teacher ready
//  iData_AM_Sample    in  NI*WV      input vector
//  iData_AM_Teach     in  NO*WD      teacher vector (same transfer; ignored in INFER)
//  oValid_BM_Input / iReady_BM_Input / oData_BM_Input   out/in/out  1/1/NI*WV   to network input
//  oValid_BM_Teacher / iReady_BM_Teacher / oData_BM_Teacher  out/in/out  1/1/NO*WD  to network teacher
//  iValid_AM_Output / oReady_AM_Output / iData_AM_Output  in/out/in  1/1/NO*WD  from network output
//  oValid_BM_Result / iReady_BM_Result / oData_BM_Result  out/in/out  1/1/NO*WD  inference results
//  oMode              out 1          1=train, 0=infer, to network
//  oLR                out WV         current learning rate, to network
//  oBusy              out 1          state != IDLE
//  oEpoch             out WC         completed epochs
//  oDone              out 1          one-cycle pulse on completion or abort
// BEHAVIOUR
//  Reset: state IDLE. oMode=0, oLR=0, oEpoch=0, oDone=0, oBusy=0. All valids=0. FIFO empty. inflight=0. issued=0.
//  Reset mid-operation: same values immediately; in-flight data abandoned.
//  FSM: IDLE -start-> TRAIN -> DRAIN_T -> INFER -> DRAIN_I -> (epoch+1 == E ? DONE : TRAIN with LR update).
//   DONE lasts 1 cycle (oDone=1), then IDLE. Start with E=0: IDLE->DONE->IDLE.
//   A phase with count 0 is passed through in one cycle.
//  TRAIN/INFER leave when issued==count (issued clears on entry). DRAIN_x leave when inflight==0 and FIFO empty.
//  iAbort in TRAIN/INFER: go to that phase's DRAIN; after drain go to DONE (oEpoch not incremented). Ignored elsewhere.
//  oMode=1 in TRAIN,DRAIN_T; 0 otherwise. oLR=iLR latched on start; updated on DRAIN_I->TRAIN.
//  Issue gate g = (TRAIN|INFER) & issued<count & inflight<MAXF & (INFER | !fifo_full); g registered-state only.
//  Gate is never a function of iValid.
//   oValid_BM_Input = iValid_AM_Sample & g. oReady_AM_Sample = iReady_BM_Input & g. Data passes through combinationally.
//   Handshake: issued++, inflight++. In TRAIN the teacher is also pushed to FIFO (same cycle).
//  Teacher FIFO: MAXF deep, oValid_BM_Teacher = !empty, registered-output head; push to empty is visible next cycle.
//   Simultaneous push+pop when full is not possible (gated).
//  Output: handshake on iValid_AM_Output&oReady_AM_Output -> inflight--.
//   Simultaneous in/out handshakes leave inflight unchanged.
//  In INFER/DRAIN_I: oValid_BM_Result=iValid_AM_Output, oReady_AM_Output=iReady_BM_Result.
//  Elsewhere: oReady_AM_Output=1, result discarded, oValid_BM_Result=0.
//  inflight never underflows; a decrement at 0 is ignored.
//  LR decay: lr-(lr>>LR_DECAY) in WV bits unsigned; result 0 forced to 1.
// TESTING
//  E=2,NT=3,NV=2,LR=64, always-ready sinks -> 3 train+2 infer inputs/epoch, 4 results out, oLR 64->56, oEpoch=2, oDone once.
//  Network output stalled, MAXF=8, NT=20 -> exactly 8 inputs accepted, oReady_AM_Sample=0 until an output returns.
//  Teacher sink stalled in TRAIN -> FIFO fills to 8, issue stops; release -> teachers out in order, DRAIN_T waits FIFO empty.
//  iAbort after 2 of NT=5 -> no further accepts, drain, oDone pulse, IDLE, oEpoch=0.
//  LR=1, LR_DECAY=3, E=3 -> oLR stays 1; E=0 start -> oDone next cycle, no transfers.
//  iRST asserted mid-INFER with 3 in flight -> all outputs at reset values same cycle, FIFO empty, restart works.

Source files
------------

// File: rtl/train_sequencer_if.sv
// Stream bundle between the sequencer and its sample source, network and sinks.
// master = sequencer side, slave = environment side.
interface train_sequencer_if #(
  parameter int NI  = 4,
  parameter int NO  = 7,
  parameter int NH1 = 6,
  parameter int WV  = 8
);
  localparam int WD = $clog2(NH1) + 1 + WV;

  logic             iValid_AM_Sample;
  logic             oReady_AM_Sample;
  logic [NI*WV-1:0] iData_AM_Sample;
  logic [NO*WD-1:0] iData_AM_Teach;

  logic             oValid_BM_Input;
  logic             iReady_BM_Input;
  logic [NI*WV-1:0] oData_BM_Input;

  logic             oValid_BM_Teacher;
  logic             iReady_BM_Teacher;
  logic [NO*WD-1:0] oData_BM_Teacher;

  logic             iValid_AM_Output;
  logic             oReady_AM_Output;
  logic [NO*WD-1:0] iData_AM_Output;

  logic             oValid_BM_Result;
  logic             iReady_BM_Result;
  logic [NO*WD-1:0] oData_BM_Result;

  modport master (
    input  iValid_AM_Sample, iData_AM_Sample, iData_AM_Teach,
    output oReady_AM_Sample,
    output oValid_BM_Input, oData_BM_Input,
    input  iReady_BM_Input,
    output oValid_BM_Teacher, oData_BM_Teacher,
    input  iReady_BM_Teacher,
    input  iValid_AM_Output, iData_AM_Output,
    output oReady_AM_Output,
    output oValid_BM_Result, oData_BM_Result,
    input  iReady_BM_Result
  );

  modport slave (
    output iValid_AM_Sample, iData_AM_Sample, iData_AM_Teach,
    input  oReady_AM_Sample,
    input  oValid_BM_Input, oData_BM_Input,
    output iReady_BM_Input,
    input  oValid_BM_Teacher, oData_BM_Teacher,
    output iReady_BM_Teacher,
    output iValid_AM_Output, iData_AM_Output,
    input  oReady_AM_Output,
    input  oValid_BM_Result, oData_BM_Result,
    output iReady_BM_Result
  );
endinterface

// File: rtl/train_sequencer.sv
// Epoch/phase controller in front of the MLP: splits sample+teacher stream,
// drives mode and learning rate, buffers teachers until the network takes them.
module train_sequencer #(
  parameter int NI       = 4,
  parameter int NO       = 7,
  parameter int NH1      = 6,
  parameter int WV       = 8,
  parameter int MAXF     = 8,
  parameter int WC       = 16,
  parameter int LR_DECAY = 3
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iStart,
  input  logic          iAbort,
  input  logic [WC-1:0] iEpochs,
  input  logic [WC-1:0] iTrainSamples,
  input  logic [WC-1:0] iInferSamples,
  input  logic [WV-1:0] iLR,
  train_sequencer_if.master bus,
  output logic          oMode,
  output logic [WV-1:0] oLR,
  output logic          oBusy,
  output logic [WC-1:0] oEpoch,
  output logic          oDone
);
  localparam int WD = $clog2(NH1) + 1 + WV;
  localparam int DT = NO * WD;
  localparam int AW = $clog2(MAXF);
  localparam int FW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_TRAIN, S_DRAIN_T, S_INFER, S_DRAIN_I, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WC-1:0] epochs_q;
  logic [WC-1:0] nt_q;
  logic [WC-1:0] nv_q;
  logic [WV-1:0] lr_q;
  logic [WC-1:0] epoch_q;
  logic [WC-1:0] issued_q;
  logic [FW-1:0] inflight_q;
  logic          aborted_q;

  logic [DT-1:0] mem [MAXF];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [FW-1:0] fcnt;

  logic          in_phase;
  logic          res_phase;
  logic [WC-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          issue_ok;
  logic          hs_in;
  logic          hs_out;
  logic          dec;
  logic          push;
  logic          pop;
  logic          drained;
  logic          last_epoch;
  logic [WV-1:0] lr_dec;
  logic [WV-1:0] lr_next;

  always_comb begin
    in_phase   = (state == S_TRAIN) || (state == S_INFER);
    res_phase  = (state == S_INFER) || (state == S_DRAIN_I);
    count      = (state == S_TRAIN) ? nt_q : nv_q;
    fifo_empty = (fcnt == '0);
    fifo_full  = (fcnt == FW'(MAXF));
    // Gate depends on registered state only, never on the source valid
    issue_ok   = in_phase && (issued_q < count)
              && (inflight_q < FW'(MAXF))
              && ((state == S_INFER) || !fifo_full);
    hs_in      = bus.iValid_AM_Sample && bus.iReady_BM_Input && issue_ok;
    push       = hs_in && (state == S_TRAIN);
    pop        = !fifo_empty && bus.iReady_BM_Teacher;
    drained    = (inflight_q == '0) && fifo_empty;
    last_epoch = (epoch_q + WC'(1)) == epochs_q;
    lr_dec     = lr_q - (lr_q >> LR_DECAY);
    lr_next    = (lr_dec == '0) ? WV'(1) : lr_dec;
  end

  always_comb begin
    bus.oValid_BM_Input   = bus.iValid_AM_Sample && issue_ok;
    bus.oReady_AM_Sample  = bus.iReady_BM_Input && issue_ok;
    bus.oData_BM_Input    = bus.iData_AM_Sample;
    bus.oValid_BM_Teacher = !fifo_empty;
    bus.oData_BM_Teacher  = mem[rd_ptr];
    bus.oValid_BM_Result  = res_phase && bus.iValid_AM_Output;
    bus.oReady_AM_Output  = res_phase ? bus.iReady_BM_Result : 1'b1;
    bus.oData_BM_Result   = bus.iData_AM_Output;
    hs_out = bus.iValid_AM_Output && bus.oReady_AM_Output;
    dec    = hs_out && (inflight_q != '0);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (iStart)
          state_nxt = (iEpochs == '0) ? S_DONE : S_TRAIN;
      end
      S_TRAIN: begin
        if (iAbort || issued_q == nt_q)
          state_nxt = S_DRAIN_T;
      end
      S_DRAIN_T: begin
        if (drained)
          state_nxt = aborted_q ? S_DONE : S_INFER;
      end
      S_INFER: begin
        if (iAbort || issued_q == nv_q)
          state_nxt = S_DRAIN_I;
      end
      S_DRAIN_I: begin
        if (drained)
          state_nxt = (aborted_q || last_epoch) ? S_DONE : S_TRAIN;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oMode = (state == S_TRAIN) || (state == S_DRAIN_T);
    oBusy = (state != S_IDLE);
    oDone = (state == S_DONE);
    oLR    = lr_q;
    oEpoch = epoch_q;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      epochs_q  <= '0;
      nt_q      <= '0;
      nv_q      <= '0;
      lr_q      <= '0;
      epoch_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (state == S_IDLE && iStart) begin
        epochs_q  <= iEpochs;
        nt_q      <= iTrainSamples;
        nv_q      <= iInferSamples;
        lr_q      <= iLR;
        epoch_q   <= '0;
        aborted_q <= 1'b0;
      end
      if (in_phase && iAbort)
        aborted_q <= 1'b1;
      // An epoch completes only at a clean end of inference drain
      if (state == S_DRAIN_I && drained && !aborted_q) begin
        epoch_q <= epoch_q + WC'(1);
        if (!last_epoch)
          lr_q <= lr_next;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      issued_q   <= '0;
      inflight_q <= '0;
    end else begin
      issued_q <= in_phase ? issued_q + WC'(hs_in) : '0;
      unique case ({hs_in, dec})
        2'b10:   inflight_q <= inflight_q + FW'(1);
        2'b01:   inflight_q <= inflight_q - FW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fcnt <= fcnt + FW'(1);
        2'b01:   fcnt <= fcnt - FW'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (push) mem[wr_ptr] <= bus.iData_AM_Teach;
  end

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer with a 1-cycle network model.
// Sample index equals the running count of accepted inputs.
module tb_train_sequencer;
  localparam int NI = 4;
  localparam int NO = 7;
  localparam int NH1 = 6;
  localparam int WV = 8;
  localparam int MAXF = 8;
  localparam int WC = 16;
  localparam int LR_DECAY = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] epochs = '0;
  logic [15:0] nt = '0;
  logic [15:0] nv = '0;
  logic [7:0]  lr = '0;
  logic        mode;
  logic [7:0]  lr_o;
  logic        busy;
  logic [15:0] epoch_o;
  logic        done;

  int n_vec = 0;
  int n_bad = 0;
  int n_in = 0;
  int n_done = 0;
  bit src_en = 1'b0;
  bit net_en = 1'b0;

  logic [31:0] netq [$];
  logic [83:0] tlog [$];
  logic [83:0] rlog [$];

  train_sequencer_if #(.NI(NI), .NO(NO), .NH1(NH1), .WV(WV)) ifc ();

  train_sequencer #(
    .NI(NI), .NO(NO), .NH1(NH1), .WV(WV),
    .MAXF(MAXF), .WC(WC), .LR_DECAY(LR_DECAY)
  ) dut (
    .iCLK(clk), .iRST(rst), .iStart(start), .iAbort(abort),
    .iEpochs(epochs), .iTrainSamples(nt), .iInferSamples(nv),
    .iLR(lr), .bus(ifc), .oMode(mode), .oLR(lr_o),
    .oBusy(busy), .oEpoch(epoch_o), .oDone(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_sample(input int i);
    return 32'h5A00_0000 + 32'(i);
  endfunction

  function automatic logic [83:0] mk_teach(input int i);
    return {20'hC0FFE, 32'(i), 32'hDEAD_0000 + 32'(i)};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      netq.delete();
    end else begin
      if (ifc.oValid_BM_Input && ifc.iReady_BM_Input) begin
        netq.push_back(ifc.oData_BM_Input);
        n_in <= n_in + 1;
      end
      if (ifc.iValid_AM_Output && ifc.oReady_AM_Output && netq.size() > 0)
        netq.pop_front();
      if (ifc.oValid_BM_Teacher && ifc.iReady_BM_Teacher)
        tlog.push_back(ifc.oData_BM_Teacher);
      if (ifc.oValid_BM_Result && ifc.iReady_BM_Result)
        rlog.push_back(ifc.oData_BM_Result);
      if (done) n_done <= n_done + 1;
    end
  end

  always @(negedge clk) begin
    ifc.iValid_AM_Sample <= src_en;
    ifc.iData_AM_Sample  <= mk_sample(n_in);
    ifc.iData_AM_Teach   <= mk_teach(n_in);
    ifc.iValid_AM_Output <= net_en && (netq.size() > 0);
    ifc.iData_AM_Output  <= (netq.size() > 0) ? {52'd0, netq[0]} : '0;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick(input int e, input int t, input int v, input int l);
    epochs = 16'(e);
    nt = 16'(t);
    nv = 16'(v);
    lr = 8'(l);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int b = n_done;
    int k = 0;
    while (n_done == b && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    ok = (n_done != b);
  endtask

  task automatic test_reset();
    src_en = 1'b1;
    cyc(2);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || mode !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: busy=%b done=%b mode=%b want 000", busy, done, mode);
    end
    n_vec++;
    if (lr_o !== 8'd0 || epoch_o !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_regs: lr=%0d epoch=%0d want 0 0", lr_o, epoch_o);
    end
    n_vec++;
    if (ifc.oValid_BM_Input !== 1'b0 || ifc.oReady_AM_Sample !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in: v=%b r=%b want 0 0", ifc.oValid_BM_Input, ifc.oReady_AM_Sample);
    end
    n_vec++;
    if (ifc.oValid_BM_Teacher !== 1'b0 || ifc.oValid_BM_Result !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: tv=%b rv=%b want 0 0", ifc.oValid_BM_Teacher, ifc.oValid_BM_Result);
    end
    src_en = 1'b0;
  endtask

  task automatic test_basic();
    int b = n_in;
    int bt = tlog.size();
    int br = rlog.size();
    int bd = n_done;
    int tix [6] = '{0, 1, 2, 5, 6, 7};
    int rix [4] = '{3, 4, 8, 9};
    bit ok;
    src_en = 1'b1;
    net_en = 1'b1;
    kick(2, 3, 2, 64);
    n_vec++;
    if (mode !== 1'b1 || lr_o !== 8'd64 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_start: mode=%b lr=%0d busy=%b want 1 64 1", mode, lr_o, busy);
    end
    wait_done(500, ok);
    cyc(3);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL basic_done: no oDone within 500 cycles");
    end
    n_vec++;
    if (n_in - b !== 10 || tlog.size() - bt !== 6 || rlog.size() - br !== 4) begin
      n_bad++;
      $display("FAIL basic_counts: in=%0d teach=%0d res=%0d want 10 6 4",
               n_in - b, tlog.size() - bt, rlog.size() - br);
    end
    n_vec++;
    if (epoch_o !== 16'd2 || lr_o !== 8'd56 || n_done - bd !== 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_end: epoch=%0d lr=%0d dones=%0d busy=%b want 2 56 1 0",
               epoch_o, lr_o, n_done - bd, busy);
    end
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (bt + k >= tlog.size() || tlog[bt+k] !== mk_teach(b + tix[k])) begin
        n_bad++;
        $display("FAIL basic_teach[%0d]: got %h want %h", k,
                 (bt + k < tlog.size()) ? tlog[bt+k] : 84'hx, mk_teach(b + tix[k]));
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (br + k >= rlog.size() || rlog[br+k] !== {52'd0, mk_sample(b + rix[k])}) begin
        n_bad++;
        $display("FAIL basic_res[%0d]: got %h want %h", k,
                 (br + k < rlog.size()) ? rlog[br+k] : 84'hx, {52'd0, mk_sample(b + rix[k])});
      end
    end
  endtask

  task automatic test_out_stall();
    int b = n_in;
    int br = rlog.size();
    bit ok;
    src_en = 1'b1;
    net_en = 1'b0;
    kick(1, 20, 0, 10);
    cyc(30);
    n_vec++;
    if (n_in - b !== 8 || ifc.oReady_AM_Sample !== 1'b0 || mode !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_cap: in=%0d rdy=%b mode=%b want 8 0 1",
               n_in - b, ifc.oReady_AM_Sample, mode);
    end
    net_en = 1'b1;
    wait_done(300, ok);
    n_vec++;
    if (!ok || n_in - b !== 20 || epoch_o !== 16'd1 || rlog.size() !== br) begin
      n_bad++;
      $display("FAIL stall_end: ok=%b in=%0d epoch=%0d res=%0d want 1 20 1 0",
               ok, n_in - b, epoch_o, rlog.size() - br);
    end
  endtask

  task automatic test_teacher_stall();
    int b = n_in;
    int bt = tlog.size();
    int bd;
    bit ok;
    src_en = 1'b1;
    net_en = 1'b1;
    ifc.iReady_BM_Teacher = 1'b0;
    kick(1, 10, 0, 10);
    cyc(30);
    n_vec++;
    if (n_in - b !== 8 || ifc.oReady_AM_Sample !== 1'b0 ||
        ifc.oValid_BM_Teacher !== 1'b1 || tlog.size() !== bt) begin
      n_bad++;
      $display("FAIL tstall_full: in=%0d rdy=%b tv=%b out=%0d want 8 0 1 0",
               n_in - b, ifc.oReady_AM_Sample, ifc.oValid_BM_Teacher, tlog.size() - bt);
    end
    ifc.iReady_BM_Teacher = 1'b1;
    wait_done(300, ok);
    n_vec++;
    if (!ok || tlog.size() - bt !== 10) begin
      n_bad++;
      $display("FAIL tstall_end: ok=%b teach=%0d want 1 10", ok, tlog.size() - bt);
    end
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (bt + k >= tlog.size() || tlog[bt+k] !== mk_teach(b + k)) begin
        n_bad++;
        $display("FAIL tstall_order[%0d]: got %h want %h", k,
                 (bt + k < tlog.size()) ? tlog[bt+k] : 84'hx, mk_teach(b + k));
      end
    end
    ifc.iReady_BM_Teacher = 1'b0;
    bd = n_done;
    kick(1, 2, 0, 10);
    cyc(20);
    n_vec++;
    if (mode !== 1'b1 || busy !== 1'b1 || n_done !== bd) begin
      n_bad++;
      $display("FAIL drain_t_wait: mode=%b busy=%b dones=%0d want 1 1 0",
               mode, busy, n_done - bd);
    end
    ifc.iReady_BM_Teacher = 1'b1;
    wait_done(100, ok);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL drain_t_end: no oDone within 100 cycles");
    end
  endtask

  task automatic test_abort();
    int b = n_in;
    int br = rlog.size();
    int bd = n_done;
    int k = 0;
    bit ok;
    src_en = 1'b1;
    net_en = 1'b1;
    kick(1, 5, 2, 20);
    while (n_in - b < 2 && k < 20) begin
      cyc(1);
      k++;
    end
    src_en = 1'b0;
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    src_en = 1'b1;
    wait_done(100, ok);
    cyc(3);
    n_vec++;
    if (!ok || n_in - b !== 2 || rlog.size() !== br) begin
      n_bad++;
      $display("FAIL abort_xfer: ok=%b in=%0d res=%0d want 1 2 0", ok, n_in - b, rlog.size() - br);
    end
    n_vec++;
    if (epoch_o !== 16'd0 || busy !== 1'b0 || n_done - bd !== 1) begin
      n_bad++;
      $display("FAIL abort_end: epoch=%0d busy=%b dones=%0d want 0 0 1",
               epoch_o, busy, n_done - bd);
    end
    src_en = 1'b0;
  endtask

  task automatic test_lr();
    int b;
    bit ok;
    src_en = 1'b1;
    net_en = 1'b1;
    kick(3, 1, 1, 1);
    wait_done(200, ok);
    n_vec++;
    if (!ok || lr_o !== 8'd1 || epoch_o !== 16'd3) begin
      n_bad++;
      $display("FAIL lr_one: ok=%b lr=%0d epoch=%0d want 1 1 3", ok, lr_o, epoch_o);
    end
    kick(2, 1, 0, 9);
    wait_done(200, ok);
    n_vec++;
    if (!ok || lr_o !== 8'd8) begin
      n_bad++;
      $display("FAIL lr_nine: ok=%b lr=%0d want 1 8", ok, lr_o);
    end
    b = n_in;
    kick(2, 0, 0, 0);
    wait_done(50, ok);
    n_vec++;
    if (!ok || lr_o !== 8'd1 || epoch_o !== 16'd2 || n_in !== b) begin
      n_bad++;
      $display("FAIL lr_zero: ok=%b lr=%0d epoch=%0d in=%0d want 1 1 2 0",
               ok, lr_o, epoch_o, n_in - b);
    end
    kick(0, 3, 3, 50);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL e0_done: done=%b busy=%b want 1 1", done, busy);
    end
    cyc(1);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0 || n_in !== b || epoch_o !== 16'd0) begin
      n_bad++;
      $display("FAIL e0_idle: done=%b busy=%b in=%0d epoch=%0d want 0 0 0 0",
               done, busy, n_in - b, epoch_o);
    end
    src_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b = n_in;
    int br;
    int k = 0;
    bit ok;
    src_en = 1'b1;
    net_en = 1'b0;
    kick(1, 0, 5, 40);
    while (n_in - b < 3 && k < 30) begin
      cyc(1);
      k++;
    end
    src_en = 1'b0;
    cyc(2);
    n_vec++;
    if (mode !== 1'b0 || busy !== 1'b1 || ifc.oReady_AM_Sample !== 1'b1 || n_in - b !== 3) begin
      n_bad++;
      $display("FAIL rmid_pre: mode=%b busy=%b rdy=%b in=%0d want 0 1 1 3",
               mode, busy, ifc.oReady_AM_Sample, n_in - b);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 1'b0 || lr_o !== 8'd0 || mode !== 1'b0 ||
        ifc.oReady_AM_Sample !== 1'b0 || ifc.oValid_BM_Teacher !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_rst: busy=%b lr=%0d mode=%b rdy=%b tv=%b want 0 0 0 0 0",
               busy, lr_o, mode, ifc.oReady_AM_Sample, ifc.oValid_BM_Teacher);
    end
    cyc(1);
    rst = 1'b0;
    net_en = 1'b1;
    src_en = 1'b1;
    cyc(1);
    b = n_in;
    br = rlog.size();
    kick(1, 2, 1, 40);
    wait_done(200, ok);
    n_vec++;
    if (!ok || n_in - b !== 3 || epoch_o !== 16'd1 || rlog.size() - br !== 1) begin
      n_bad++;
      $display("FAIL rmid_restart: ok=%b in=%0d epoch=%0d res=%0d want 1 3 1 1",
               ok, n_in - b, epoch_o, rlog.size() - br);
    end
    n_vec++;
    if (br >= rlog.size() || rlog[br] !== {52'd0, mk_sample(b + 2)}) begin
      n_bad++;
      $display("FAIL rmid_res: got %h want %h",
               (br < rlog.size()) ? rlog[br] : 84'hx, {52'd0, mk_sample(b + 2)});
    end
    src_en = 1'b0;
  endtask

  initial begin
    ifc.iReady_BM_Input = 1'b1;
    ifc.iReady_BM_Teacher = 1'b1;
    ifc.iReady_BM_Result = 1'b1;
    cyc(3);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_out_stall();
    test_teacher_stall();
    test_abort();
    test_lr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
